// File: rtl/food_position_generator.sv
// Snake food placer: an LFSR proposes grid-aligned cells, the border and an
// external occupancy lookup reject them, and a bounded retry count ends in a fallback.
module food_position_generator #(
    parameter int                LFSR_W     = 20,
    parameter logic [LFSR_W-1:0] TAPS       = LFSR_W'(20'h00009),
    parameter logic [LFSR_W-1:0] SEED       = LFSR_W'(212701),
    parameter int                SCREEN_W   = 640,
    parameter int                SCREEN_H   = 480,
    parameter int                CELL       = 10,
    parameter int                BORDER     = 1,
    parameter int                MAX_TRIES  = 16,
    parameter int                FALLBACK_X = 320,
    parameter int                FALLBACK_Y = 240
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              seed_load,
    input  logic [LFSR_W-1:0] seed,
    input  logic              req,
    output logic              busy,
    output logic              valid,
    output logic              fallback,
    output logic [9:0]        pos_x,
    output logic [9:0]        pos_y,
    output logic              cand_valid,
    output logic [9:0]        cand_x,
    output logic [9:0]        cand_y,
    input  logic              cand_blocked
);

    localparam int COLS = SCREEN_W / CELL;
    localparam int ROWS = SCREEN_H / CELL;
    localparam int CB   = $clog2(COLS);
    localparam int RB   = $clog2(ROWS);
    localparam int TW   = $clog2(MAX_TRIES + 1);

    localparam logic [CB-1:0] COL_MIN   = CB'(BORDER);
    localparam logic [CB-1:0] COL_MAX   = CB'(COLS - 1 - BORDER);
    localparam logic [RB-1:0] ROW_MIN   = RB'(BORDER);
    localparam logic [RB-1:0] ROW_MAX   = RB'(ROWS - 1 - BORDER);
    localparam logic [TW-1:0] TRIES_MAX = TW'(MAX_TRIES);

    if (CB + RB > LFSR_W) begin : g_width_check
        $error("LFSR too narrow for the column and row fields");
    end
    if (SEED == '0) begin : g_seed_check
        $error("SEED must be non-zero");
    end
    if ((SCREEN_W % CELL != 0) || (SCREEN_H % CELL != 0)) begin : g_cell_check
        $error("CELL must divide the screen dimensions");
    end
    if ((SCREEN_W > 1024) || (SCREEN_H > 1024)) begin : g_range_check
        $error("pixel coordinates must fit in 10 bits");
    end

    typedef enum logic [1:0] {IDLE, DRAW, QUERY, DONE} state_t;

    state_t            state, state_next;
    logic [TW-1:0]     tries, tries_next;
    logic [LFSR_W-1:0] lfsr, lfsr_step;
    logic [CB-1:0]     col_raw;
    logic [RB-1:0]     row_raw;
    logic [9:0]        col_px, row_px;
    logic              in_range;
    logic              load_cand, load_pos, load_fb;

    assign lfsr_step = {^(lfsr & TAPS), lfsr[LFSR_W-1:1]};
    assign col_raw   = lfsr[CB-1:0];
    assign row_raw   = lfsr[CB+RB-1:CB];
    assign in_range  = (col_raw >= COL_MIN) && (col_raw <= COL_MAX) &&
                       (row_raw >= ROW_MIN) && (row_raw <= ROW_MAX);
    assign col_px    = 10'(col_raw) * 10'(CELL);
    assign row_px    = 10'(row_raw) * 10'(CELL);

    assign busy       = (state != IDLE);
    assign valid      = (state == DONE);
    assign cand_valid = (state == QUERY);

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path can infer a latch.
        state_next = state;
        tries_next = tries;
        load_cand  = 1'b0;
        load_pos   = 1'b0;
        load_fb    = 1'b0;
        unique case (state)
            IDLE: begin
                if (req) begin
                    state_next = DRAW;
                    tries_next = '0;
                end
            end
            DRAW: begin
                tries_next = tries + TW'(1);
                if (in_range) begin
                    load_cand  = 1'b1;
                    state_next = QUERY;
                end else if (tries_next >= TRIES_MAX) begin
                    load_fb    = 1'b1;
                    state_next = DONE;
                end
            end
            QUERY: begin
                if (!cand_blocked) begin
                    load_pos   = 1'b1;
                    state_next = DONE;
                end else if (tries < TRIES_MAX) begin
                    state_next = DRAW;
                end else begin
                    load_fb    = 1'b1;
                    state_next = DONE;
                end
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // The LFSR keeps stepping in every state so request timing adds entropy.
    always_ff @(posedge clock) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (reset) begin
            state    <= IDLE;
            tries    <= '0;
            lfsr     <= SEED;
            pos_x    <= '0;
            pos_y    <= '0;
            cand_x   <= '0;
            cand_y   <= '0;
            fallback <= 1'b0;
        end else begin
            state <= state_next;
            tries <= tries_next;
            if (seed_load) begin
                lfsr <= (seed == '0) ? SEED : seed;
            end else begin
                lfsr <= lfsr_step;
            end
            if (load_cand) begin
                cand_x <= col_px;
                cand_y <= row_px;
            end
            if (load_pos) begin
                pos_x    <= cand_x;
                pos_y    <= cand_y;
                fallback <= 1'b0;
            end else if (load_fb) begin
                pos_x    <= 10'(FALLBACK_X);
                pos_y    <= 10'(FALLBACK_Y);
                fallback <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_food_position_generator.sv
// Directed bench for food_position_generator: hand-computed draws from known
// seeds plus a small LFSR/FSM reference model for timing-dependent cases.
module tb_food_position_generator;

    logic        clock = 1'b0;
    logic        reset;
    logic        seed_load;
    logic [19:0] seed;
    logic        req;
    logic        busy, valid, fallback, cand_valid, cand_blocked;
    logic [9:0]  pos_x, pos_y, cand_x, cand_y;

    int          errors = 0;
    int          checks = 0;
    logic [19:0] mdl;

    food_position_generator dut (
        .clock        (clock),
        .reset        (reset),
        .seed_load    (seed_load),
        .seed         (seed),
        .req          (req),
        .busy         (busy),
        .valid        (valid),
        .fallback     (fallback),
        .pos_x        (pos_x),
        .pos_y        (pos_y),
        .cand_valid   (cand_valid),
        .cand_x       (cand_x),
        .cand_y       (cand_y),
        .cand_blocked (cand_blocked)
    );

    always #5 clock = ~clock;

    function automatic logic [19:0] step(input logic [19:0] l);
        return {l[0] ^ l[3], l[19:1]};
    endfunction

    // Reference LFSR driven only by the bench's own inputs.
    always @(posedge clock) begin
        if (reset)          mdl <= 20'd212701;
        else if (seed_load) mdl <= (seed == 20'd0) ? 20'd212701 : seed;
        else                mdl <= step(mdl);
    end

    // Outcome of a draw whose first DRAW cycle sees l0; lat counts cycles from the req cycle to valid.
    task automatic predict(input logic [19:0] l0, input logic blk, output logic [9:0] px,
                           output logic [9:0] py, output logic fb, output int lat);
        logic [19:0] l;
        logic [5:0]  c, r;
        int          t;
        bit          done;
        l = l0; t = 0; lat = 1; done = 0; px = '0; py = '0; fb = 1'b0;
        while (!done) begin
            t++;
            c = l[5:0];
            r = l[11:6];
            if (c >= 6'd1 && c <= 6'd62 && r >= 6'd1 && r <= 6'd46) begin
                lat++;
                l = step(l);
                if (!blk) begin
                    px = {4'd0, c} * 10'd10; py = {4'd0, r} * 10'd10; fb = 1'b0; lat++; done = 1;
                end else if (t < 16) begin
                    lat++;
                    l = step(l);
                end else begin
                    px = 10'd320; py = 10'd240; fb = 1'b1; lat++; done = 1;
                end
            end else if (t >= 16) begin
                px = 10'd320; py = 10'd240; fb = 1'b1; lat++; done = 1;
            end else begin
                lat++;
                l = step(l);
            end
        end
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Called at a negedge: raise req for one cycle, return the cycles until valid (bounded).
    task automatic do_req(output int cyc);
        req = 1'b1;
        @(negedge clock);
        req       = 1'b0;
        seed_load = 1'b0;
        cyc = 1;
        while (!valid && cyc < 40) begin
            @(negedge clock);
            cyc++;
        end
    endtask

    initial begin
        int          cyc, el, nvalid;
        logic [9:0]  ex, ey;
        logic        ef;

        reset = 1'b1; seed_load = 1'b0; seed = '0; req = 1'b0; cand_blocked = 1'b0;
        repeat (3) @(negedge clock);
        check("reset_busy",  32'(busy), 0);
        check("reset_flags", 32'({valid, fallback, cand_valid}), 0);
        check("reset_pos",   32'({pos_x, pos_y}), 0);
        check("reset_cand",  32'({cand_x, cand_y}), 0);

        // Default seed: third LFSR successor 0xC67DB is the first in-range cell (27,31).
        reset = 1'b0;
        repeat (2) @(negedge clock);
        do_req(cyc);
        check("first_latency", 32'(cyc), 3);
        check("first_valid",   32'(valid), 1);
        check("first_pos_x",   32'(pos_x), 270);
        check("first_pos_y",   32'(pos_y), 310);
        check("first_fb",      32'(fallback), 0);
        check("first_busy",    32'(busy), 1);
        check("first_grid",    32'(pos_x % 10 == 0 && pos_y % 10 == 0 && pos_x >= 10 &&
                                   pos_x <= 620 && pos_y >= 10 && pos_y <= 460), 1);
        @(negedge clock);
        check("pulse_end",     32'({valid, busy}), 0);
        check("pos_hold",      32'({pos_x, pos_y}), 32'({10'd270, 10'd310}));

        // Zero seed reloads 212701: out, out, out, then (27,31).
        seed_load = 1'b1; seed = 20'd0;
        do_req(cyc);
        check("seed0_latency", 32'(cyc), 6);
        check("seed0_pos",     32'({pos_x, pos_y}), 32'({10'd270, 10'd310}));

        // Seed 1: a single bit walks down with row or column never in range -> 16 rejected draws.
        @(negedge clock);
        seed_load = 1'b1; seed = 20'h00001;
        do_req(cyc);
        check("seed1_latency", 32'(cyc), 17);
        check("seed1_fb",      32'(fallback), 1);
        check("seed1_pos",     32'({pos_x, pos_y}), 32'({10'd320, 10'd240}));

        // Seed 0x2BF: column 63 rejected, successor 0x15F gives cell (31,5).
        @(negedge clock);
        seed_load = 1'b1; seed = 20'h002BF; req = 1'b1;
        @(negedge clock);
        seed_load = 1'b0; req = 1'b0;
        check("border_d1_cv",   32'({busy, cand_valid}), 32'(2'b10));
        check("border_cand_hold", 32'({cand_x, cand_y}), 32'({10'd270, 10'd310}));
        @(negedge clock);
        check("border_d2_cv",   32'(cand_valid), 0);
        @(negedge clock);
        check("border_q_cv",    32'(cand_valid), 1);
        check("border_cand",    32'({cand_x, cand_y}), 32'({10'd310, 10'd50}));
        @(negedge clock);
        check("border_valid",   32'({valid, fallback}), 32'(2'b10));
        check("border_pos",     32'({pos_x, pos_y}), 32'({10'd310, 10'd50}));

        // Request pulsed while busy must not produce a second result.
        @(negedge clock);
        seed_load = 1'b1; seed = 20'h002BF; req = 1'b1;
        @(negedge clock);
        seed_load = 1'b0; req = 1'b0;
        nvalid = 0;
        for (int i = 2; i <= 12; i++) begin
            req = (i == 2);
            @(negedge clock);
            if (valid) nvalid++;
        end
        req = 1'b0;
        check("busy_one_valid", 32'(nvalid), 1);

        // Always blocked: every query is refused, result must be the fallback.
        cand_blocked = 1'b1;
        predict(step(mdl), 1'b1, ex, ey, ef, el);
        do_req(cyc);
        check("blk_latency", 32'(cyc), 32'(el));
        check("blk_bound",   32'(cyc <= 34), 1);
        check("blk_fb",      32'({valid, fallback}), 32'(2'b11));
        check("blk_pos",     32'({pos_x, pos_y}), 32'({10'd320, 10'd240}));
        cand_blocked = 1'b0;
        @(negedge clock);

        // Held req: back-to-back draws, each restarting from IDLE.
        req = 1'b1;
        for (int k = 0; k < 3; k++) begin
            if (k > 0) check("hold_idle_gap", 32'(busy), 0);
            predict(step(mdl), 1'b0, ex, ey, ef, el);
            cyc = 0;
            do begin
                @(negedge clock);
                cyc++;
            end while (!valid && cyc < 40);
            check("hold_latency", 32'(cyc), 32'(el));
            check("hold_pos",     32'({pos_x, pos_y, fallback}), 32'({ex, ey, ef}));
            if (k > 0) check("hold_spacing", 32'(cyc + 1 >= 4), 1);
            if (k < 2) @(negedge clock);
        end
        req = 1'b0;
        @(negedge clock);

        // Reset in QUERY aborts the draw without a valid.
        seed_load = 1'b1; seed = 20'h002BF; req = 1'b1;
        @(negedge clock);
        seed_load = 1'b0; req = 1'b0;
        repeat (2) @(negedge clock);
        check("mid_in_query", 32'(cand_valid), 1);
        reset = 1'b1; seed_load = 1'b1; seed = 20'h00001; req = 1'b1;
        @(negedge clock);
        reset = 1'b0; seed_load = 1'b0; req = 1'b0;
        check("mid_rst_ctl",  32'({busy, cand_valid, valid}), 0);
        check("mid_rst_pos",  32'({pos_x, pos_y}), 0);
        nvalid = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clock);
            if (valid || busy) nvalid++;
        end
        check("mid_no_valid", 32'(nvalid), 0);

        // Recovery after reset: LFSR restarted from SEED, model agrees.
        predict(step(mdl), 1'b0, ex, ey, ef, el);
        do_req(cyc);
        check("post_latency", 32'(cyc), 32'(el));
        check("post_pos",     32'({pos_x, pos_y, fallback}), 32'({ex, ey, ef}));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
